// File: rtl/led_playlist_ctrl.sv
// led_playlist_ctrl: four-entry playlist of {pattern, times} entries that
// feeds an LED engine one entry at a time. Entries are either consumed as
// they finish (loop=0) or replayed round-robin in place (loop=1).
module led_playlist_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] pat_in,
  input  logic [1:0] times_in,
  input  logic       play,
  input  logic       loop,
  input  logic       eng_done,
  output logic       eng_start,
  output logic [3:0] eng_pattern,
  output logic [1:0] eng_times,
  output logic [2:0] count,
  output logic       full,
  output logic       empty,
  output logic [1:0] cur_idx,
  output logic       busy,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;

  logic [5:0] mem_r [0:3];
  logic [1:0] head_r;
  logic [2:0] count_r;
  logic [1:0] cur_idx_r;
  logic       ovf_r;
  logic       eng_start_r;
  logic [3:0] eng_pattern_r;
  logic [1:0] eng_times_r;
  logic       busy_r;
  logic       full_r;
  logic       empty_r;

  logic       push_ok_s;
  logic       push_drop_s;
  logic       done_s;
  logic       pop_s;
  logic [1:0] wr_slot_s;
  logic [1:0] head_s;
  logic [2:0] count_s;
  logic [1:0] cur_idx_s;
  logic [1:0] rd_slot_s;
  logic [5:0] rd_data_s;

  // Buffer bookkeeping: next head/count/cur_idx and the entry the next ISSUE will present.
  always_comb begin
    push_ok_s   = push && (count_r != 3'd4);
    push_drop_s = push && (count_r == 3'd4);
    done_s      = (state_r == BUSY) && eng_done;
    pop_s       = done_s && !loop;
    wr_slot_s   = head_r + count_r[1:0];
    count_s     = count_r + {2'b00, push_ok_s} - {2'b00, pop_s};
    if (pop_s) begin
      head_s    = head_r + 2'd1;
      cur_idx_s = 2'd0;
    end else if (done_s) begin
      head_s    = head_r;
      cur_idx_s = (({1'b0, cur_idx_r} + 3'd1) == count_r) ? 2'd0 : (cur_idx_r + 2'd1);
    end else begin
      head_s    = head_r;
      cur_idx_s = cur_idx_r;
    end
    if (count_s == 3'd0) begin
      cur_idx_s = 2'd0;
    end else begin
      cur_idx_s = cur_idx_s;
    end
    rd_slot_s = head_s + cur_idx_s;
    // An entry written this very cycle can be the one issued next (e.g. pop of
    // the last entry alongside a push), so forward the incoming data.
    if (push_ok_s && (wr_slot_s == rd_slot_s)) begin
      rd_data_s = {pat_in, times_in};
    end else begin
      rd_data_s = mem_r[rd_slot_s];
    end
  end

  // Next-state logic for the issue sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (play && (count_r != 3'd0)) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = BUSY;
      end
      BUSY: begin
        if (eng_done) begin
          state_s = (play && (count_s != 3'd0)) ? ISSUE : IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Storage, pointers, sticky overflow and registered engine/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem_r[i] <= 6'd0;
      end
      head_r        <= 2'd0;
      count_r       <= 3'd0;
      cur_idx_r     <= 2'd0;
      ovf_r         <= 1'b0;
      eng_start_r   <= 1'b0;
      eng_pattern_r <= 4'd0;
      eng_times_r   <= 2'd0;
      busy_r        <= 1'b0;
      full_r        <= 1'b0;
      empty_r       <= 1'b1;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_slot_s] <= {pat_in, times_in};
      end
      head_r      <= head_s;
      count_r     <= count_s;
      cur_idx_r   <= cur_idx_s;
      ovf_r       <= ovf_r | push_drop_s;
      eng_start_r <= (state_s == ISSUE);
      if (state_s == ISSUE) begin
        eng_pattern_r <= rd_data_s[5:2];
        eng_times_r   <= rd_data_s[1:0];
      end
      busy_r  <= (state_s != IDLE);
      full_r  <= (count_s == 3'd4);
      empty_r <= (count_s == 3'd0);
    end
  end

  assign eng_start   = eng_start_r;
  assign eng_pattern = eng_pattern_r;
  assign eng_times   = eng_times_r;
  assign count       = count_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign cur_idx     = cur_idx_r;
  assign busy        = busy_r;
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_led_playlist_ctrl.sv
// Bench for led_playlist_ctrl: stimulus pushes the expected {pattern, times,
// cur_idx} of every engine start into a queue; a monitor pops on each
// eng_start. Status outputs are checked directly at scenario checkpoints.
module tb_led_playlist_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic [3:0] pat_in = 4'd0;
  logic [1:0] times_in = 2'd0;
  logic       play = 1'b0;
  logic       loop = 1'b0;
  logic       eng_done = 1'b0;
  logic       eng_start;
  logic [3:0] eng_pattern;
  logic [1:0] eng_times;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic [1:0] cur_idx;
  logic       busy;
  logic       ovf;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q [$];

  led_playlist_ctrl dut (
    .clk(clk), .reset(reset), .push(push), .pat_in(pat_in), .times_in(times_in),
    .play(play), .loop(loop), .eng_done(eng_done), .eng_start(eng_start),
    .eng_pattern(eng_pattern), .eng_times(eng_times), .count(count), .full(full),
    .empty(empty), .cur_idx(cur_idx), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Monitor: every engine start must match the oldest expected issue.
  always @(negedge clk) begin
    if (eng_start) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: got pat=%h times=%0d idx=%0d, expected no start",
                 eng_pattern, eng_times, cur_idx);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({eng_pattern, eng_times, cur_idx} !== e) begin
          errors++;
          $display("FAIL issue: got pat=%h times=%0d idx=%0d, expected pat=%h times=%0d idx=%0d",
                   eng_pattern, eng_times, cur_idx, e[7:4], e[3:2], e[1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_issue(input logic [3:0] p, input logic [1:0] t, input logic [1:0] idx);
    exp_q.push_back({p, t, idx});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_push(input logic [3:0] p, input logic [1:0] t);
    push = 1'b1;
    pat_in = p;
    times_in = t;
    tick();
    push = 1'b0;
  endtask

  task automatic done_pulse();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  // Wait (bounded) for an engine start to be visible.
  task automatic wait_start();
    int n;
    n = 0;
    while (!eng_start && n < 50) begin
      tick();
      n++;
    end
    if (!eng_start) begin
      vectors++;
      errors++;
      $display("FAIL start_timeout: got no eng_start, expected one within 50 cycles");
    end
  endtask

  task automatic run_one();
    wait_start();
    tick();
    tick();
    done_pulse();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_empty", {7'd0, empty}, 8'd1);
    check("rst_full", {7'd0, full}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_count", {5'd0, count}, 8'd0);
    check("rst_ovf", {7'd0, ovf}, 8'd0);

    // Basic consume-as-played sequence with back-to-back latency
    do_push(4'h5, 2'd2);
    do_push(4'hA, 2'd1);
    check("two_count", {5'd0, count}, 8'd2);
    expect_issue(4'h5, 2'd2, 2'd0);
    expect_issue(4'hA, 2'd1, 2'd0);
    play = 1'b1;
    tick();
    check("start_latency_idle", {7'd0, eng_start}, 8'd1);
    tick();
    done_pulse();
    check("start_latency_done", {7'd0, eng_start}, 8'd1);
    tick();
    done_pulse();
    check("drain_empty", {7'd0, empty}, 8'd1);
    check("drain_busy", {7'd0, busy}, 8'd0);

    // Overflow: fifth push is dropped and never played
    play = 1'b0;
    do_reset();
    for (int i = 1; i <= 5; i++) do_push(i[3:0], i[1:0]);
    check("ovf_count", {5'd0, count}, 8'd4);
    check("ovf_full", {7'd0, full}, 8'd1);
    check("ovf_flag", {7'd0, ovf}, 8'd1);
    for (int i = 1; i <= 4; i++) expect_issue(i[3:0], i[1:0], 2'd0);
    play = 1'b1;
    for (int i = 0; i < 4; i++) run_one();
    tick();
    check("ovf_drained", {7'd0, empty}, 8'd1);

    // Loop mode replays in place; play drop finishes the current entry
    play = 1'b0;
    do_reset();
    do_push(4'h1, 2'd1);
    do_push(4'h2, 2'd2);
    do_push(4'h3, 2'd3);
    loop = 1'b1;
    expect_issue(4'h1, 2'd1, 2'd0);
    expect_issue(4'h2, 2'd2, 2'd1);
    expect_issue(4'h3, 2'd3, 2'd2);
    expect_issue(4'h1, 2'd1, 2'd0);
    expect_issue(4'h2, 2'd2, 2'd1);
    play = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_start();
      tick();
      if (i == 4) play = 1'b0;
      done_pulse();
    end
    for (int i = 0; i < 4; i++) tick();
    check("loop_count", {5'd0, count}, 8'd3);
    check("loop_idle", {7'd0, busy}, 8'd0);
    loop = 1'b0;

    // Full buffer: push coinciding with completion is dropped
    do_reset();
    do_push(4'h6, 2'd0);
    do_push(4'h7, 2'd1);
    do_push(4'h8, 2'd2);
    do_push(4'h9, 2'd3);
    expect_issue(4'h6, 2'd0, 2'd0);
    play = 1'b1;
    wait_start();
    tick();
    play = 1'b0;
    push = 1'b1; pat_in = 4'hF; times_in = 2'd3; eng_done = 1'b1;
    tick();
    push = 1'b0; eng_done = 1'b0;
    check("full_pd_count", {5'd0, count}, 8'd3);
    check("full_pd_ovf", {7'd0, ovf}, 8'd1);
    expect_issue(4'h7, 2'd1, 2'd0);
    expect_issue(4'h8, 2'd2, 2'd0);
    expect_issue(4'h9, 2'd3, 2'd0);
    play = 1'b1;
    for (int i = 0; i < 3; i++) run_one();
    tick();
    check("full_pd_drained", {7'd0, empty}, 8'd1);

    // Count 2: push plus completion keeps count, new entry plays last
    do_reset();
    do_push(4'h1, 2'd2);
    do_push(4'h2, 2'd3);
    expect_issue(4'h1, 2'd2, 2'd0);
    expect_issue(4'h2, 2'd3, 2'd0);
    expect_issue(4'hC, 2'd1, 2'd0);
    wait_start();
    tick();
    push = 1'b1; pat_in = 4'hC; times_in = 2'd1; eng_done = 1'b1;
    tick();
    push = 1'b0; eng_done = 1'b0;
    check("pd2_count", {5'd0, count}, 8'd2);
    check("pd2_ovf", {7'd0, ovf}, 8'd0);
    run_one();
    run_one();

    // Count 1: the entry pushed on completion is issued right away
    do_reset();
    do_push(4'hD, 2'd2);
    expect_issue(4'hD, 2'd2, 2'd0);
    expect_issue(4'hE, 2'd1, 2'd0);
    wait_start();
    tick();
    push = 1'b1; pat_in = 4'hE; times_in = 2'd1; eng_done = 1'b1;
    tick();
    push = 1'b0; eng_done = 1'b0;
    check("pd1_start", {7'd0, eng_start}, 8'd1);
    tick();
    done_pulse();

    // Reset while busy clears everything; a late completion is ignored
    do_reset();
    do_push(4'h3, 2'd3);
    expect_issue(4'h3, 2'd3, 2'd0);
    wait_start();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_outs", {eng_start, eng_pattern, eng_times, busy}, 8'd0);
    check("rb_count", {ovf, count, cur_idx, 2'b00}, 8'd0);
    done_pulse();
    for (int i = 0; i < 3; i++) tick();
    check("rb_ignored", {6'd0, busy, eng_start}, 8'd0);
    play = 1'b0;

    check("queue_drained", exp_q.size() > 255 ? 8'hFF : exp_q.size()[7:0], 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/led_playlist_ctrl.md
LED_PLAYLIST_CTRL -- requirements
Module: led_playlist_ctrl

Interface
REQ-001 SHALL provide one clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 push  input  1  one-cycle strobe; enqueue {pat_in, times_in}.
REQ-005 pat_in  input  4  LED pattern code to enqueue.
REQ-006 times_in  input  2  repeat count to enqueue (passed through unmodified).
REQ-007 play  input  1  level; 1 = run queue, 0 = stop after the current entry.
REQ-008 loop  input  1  level; 1 = replay entries without removing them, 0 = remove each entry when done.
REQ-009 eng_done  input  1  one-cycle strobe from LED engine: current entry finished.
REQ-010 eng_start  output  1  one-cycle strobe to LED engine: begin entry on eng_pattern/eng_times.
REQ-011 eng_pattern  output  4  pattern code of the entry issued.
REQ-012 eng_times  output  2  repeat count of the entry issued.
REQ-013 count  output  3  number of stored entries, 0..4.
REQ-014 full / empty  output  1 each  count==4 / count==0.
REQ-015 cur_idx  output  2  play offset from head (seven-segment display).
REQ-016 busy  output  1  1 in ISSUE or BUSY state.
REQ-017 ovf  output  1  sticky: a push was dropped.

Function
REQ-018 Storage SHALL be a 4-entry circular buffer of 6-bit {pattern, times}, with a 2-bit head pointer and count; the write slot is head+count mod 4.
REQ-019 push with count<4 at the start of the cycle SHALL write one entry and increment count; push with count==4 SHALL be dropped and set ovf, even if a pop occurs in the same cycle.
REQ-020 The FSM SHALL have states IDLE, ISSUE, BUSY, encoded 0, 1, 2.
REQ-021 IDLE -> ISSUE when play==1 and count!=0; otherwise remain in IDLE.
REQ-022 ISSUE SHALL last exactly one cycle: eng_start=1, and eng_pattern/eng_times are loaded from slot head+cur_idx in the same cycle; the next state is BUSY.
REQ-023 BUSY SHALL wait for eng_done; eng_pattern/eng_times SHALL stay constant from ISSUE until the next ISSUE; eng_done in IDLE or ISSUE is ignored.
REQ-024 On eng_done in BUSY with loop==0: pop the head (head+1 mod 4, count-1) and set cur_idx=0.
REQ-025 On eng_done in BUSY with loop==1: keep all entries and advance cur_idx = (cur_idx+1==count) ? 0 : cur_idx+1, wrapping within stored entries.
REQ-026 After eng_done: go to ISSUE if play==1 and the post-update count!=0, else go to IDLE; the engine is idle for at least one cycle between consecutive starts.
REQ-027 play falling during ISSUE/BUSY SHALL not abort: the current entry completes, then the FSM returns to IDLE.
REQ-028 A loop toggle SHALL take effect at the next eng_done.
REQ-029 push and eng_done in the same cycle SHALL both take effect; the net count is unchanged.
REQ-030 cur_idx SHALL be forced to 0 whenever count becomes 0.
REQ-031 Latency: eng_start SHALL assert 1 cycle after play/count qualify in IDLE, and 1 cycle after eng_done when continuing.

Reset
REQ-032 reset==1 at a clk edge SHALL clear the FSM to IDLE and clear head, count, cur_idx, eng_start, eng_pattern, eng_times and ovf to 0, in any state; stored entries are discarded.
REQ-033 Immediately after reset: empty=1, full=0, busy=0; a reset during BUSY SHALL not generate eng_start, and a later eng_done SHALL be ignored.

Verification
REQ-034 Reset, then push (5,2), (A,1), play=1, loop=0 -> eng_start with 5/2; eng_done -> eng_start with A/1 after 1 cycle; eng_done -> IDLE, empty=1.
REQ-035 Push 5 entries with no play -> count=4, full=1, ovf=1, 5th entry absent from playback.
REQ-036 loop=1 with entries 1, 2, 3 and play=1 -> issue order 1, 2, 3, 1, 2 with cur_idx 0, 1, 2, 0, 1; count stays 3.
REQ-037 With count=4 in BUSY, push and eng_done in the same cycle (loop=0) -> push dropped, ovf=1, count=3; with count=2 -> count=2 and the new entry is played last.
REQ-038 play dropped mid-BUSY -> no further eng_start after eng_done, FSM reaches IDLE; reset asserted mid-BUSY -> all outputs 0, later eng_done ignored.
